bus_cmd_responder: RTL



---
 rtl/bus_cmd_responder.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/bus_cmd_responder.sv
// bus_cmd_responder: target endpoint that accepts one command at a time,
// executes it against a small register file and returns a tagged response.
module bus_cmd_responder #(
    parameter int DEPTH       = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_cmd,
    input  logic [7:0]  req_addr,
    input  logic [31:0] req_data,
    input  logic [3:0]  req_id,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [7:0]  rsp_addr,
    output logic [31:0] rsp_data,
    output logic [3:0]  rsp_id,
    output logic        rsp_err,
    output logic [1:0]  state
);

    localparam logic [1:0] S_IDLE   = 2'b00;
    localparam logic [1:0] S_ACTIVE = 2'b01;
    localparam logic [1:0] S_WAIT   = 2'b10;
    localparam logic [1:0] S_ERROR  = 2'b11;

    localparam logic [2:0] CMD_READ  = 3'b000;
    localparam logic [2:0] CMD_WRITE = 3'b001;
    localparam logic [2:0] CMD_ERASE = 3'b010;
    localparam logic [2:0] CMD_FLUSH = 3'b011;

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int NW = $clog2(DEPTH + 1);

    localparam logic [8:0]    DEPTH_L = 9'(DEPTH);
    localparam logic [CW-1:0] WAIT_L  = CW'(WAIT_CYCLES);

    // Captured request
    logic [1:0]    r_state;
    logic [2:0]    r_cmd;
    logic [7:0]    r_addr;
    logic [31:0]   r_data;
    logic [3:0]    r_id;
    logic [CW-1:0] r_cnt;

    // Response registers
    logic          r_rsp_valid;
    logic          r_rsp_err;
    logic [31:0]   r_rsp_data;
    logic [7:0]    r_rsp_addr;
    logic [3:0]    r_rsp_id;

    logic [31:0]   w_mem [DEPTH];
    logic [DEPTH-1:0] w_nz;
    logic [NW-1:0] w_nz_count;
    logic          w_bad;
    logic          w_exec;
    logic          w_long;
    logic          w_handshake;
    logic [31:0]   w_rd_word;

    // Illegal opcode, or an out-of-range address on anything but FLUSH.
    // The compare uses all 8 address bits so aliases above DEPTH are rejected.
    assign w_bad       = r_cmd[2] || ((r_cmd != CMD_FLUSH) && !({1'b0, r_addr} < DEPTH_L));
    assign w_exec      = (r_state == S_ACTIVE) && !w_bad;
    assign w_long      = ((r_cmd == CMD_ERASE) || (r_cmd == CMD_FLUSH)) && (WAIT_CYCLES > 0);
    assign w_handshake = r_rsp_valid && rsp_ready;
    assign w_rd_word   = w_mem[r_addr[AW-1:0]];

    // Register file: one register per word so that reset and FLUSH can clear
    // every word in a single cycle and the nonzero flags are always visible.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_word
            logic [31:0] r_word;
            logic        w_hit;

            assign w_hit = (r_addr[AW-1:0] == AW'(gi));

            // Word update on the edge leaving ACTIVE for a legal command.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_word <= '0;
                end else if (w_exec) begin
                    if (r_cmd == CMD_FLUSH) begin
                        r_word <= '0;
                    end else if (w_hit && (r_cmd == CMD_WRITE)) begin
                        r_word <= r_data;
                    end else if (w_hit && (r_cmd == CMD_ERASE)) begin
                        r_word <= '0;
                    end
                end
            end

            assign w_mem[gi] = r_word;
            assign w_nz[gi]  = |r_word;
        end
    endgenerate

    // Population count of nonzero words, reported by FLUSH.
    always_comb begin
        w_nz_count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_nz_count = w_nz_count + NW'(w_nz[i]);
        end
    end

    // Main control: capture in IDLE, execute in ACTIVE, count down and hold
    // the response in WAIT, hold the error response in ERROR.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cmd       <= '0;
            r_addr      <= '0;
            r_data      <= '0;
            r_id        <= '0;
            r_cnt       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_addr  <= '0;
            r_rsp_id    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_cmd   <= req_cmd;
                        r_addr  <= req_addr;
                        r_data  <= req_data;
                        r_id    <= req_id;
                        r_state <= S_ACTIVE;
                    end
                end
                S_ACTIVE: begin
                    r_rsp_addr <= r_addr;
                    r_rsp_id   <= r_id;
                    if (w_bad) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_rsp_data  <= '0;
                        r_state     <= S_ERROR;
                    end else begin
                        case (r_cmd)
                            CMD_READ:  r_rsp_data <= w_rd_word;
                            CMD_WRITE: r_rsp_data <= r_data;
                            CMD_FLUSH: r_rsp_data <= 32'(w_nz_count);
                            default:   r_rsp_data <= '0;
                        endcase
                        r_state <= S_WAIT;
                        if (w_long) begin
                            r_cnt       <= WAIT_L;
                            r_rsp_valid <= 1'b0;
                        end else begin
                            r_cnt       <= '0;
                            r_rsp_valid <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CW'(1);
                        if (r_cnt == CW'(1)) begin
                            r_rsp_valid <= 1'b1;
                        end
                    end else if (w_handshake) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_err   <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                S_ERROR: begin
                    if (w_handshake) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_err   <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready = (r_state == S_IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_data  = r_rsp_data;
    assign rsp_addr  = r_rsp_addr;
    assign rsp_id    = r_rsp_id;
    assign state     = r_state;

endmodule
